nor_mis_sweep: RTL and testbench

Parametrised multiple-input-switching (MIS) characterisation block: two configurable-depth NOR2_X1 inverter chains feed a NOR2_X1 MIS gate and a configurable output chain. An on-chip FSM launches input transitions on both chains with a programmable skew, sweeps the skew from -MAX_SKEW to +MAX_SKEW clock cycles, and counts synchronised output edges per skew point. It is the self-stimulating successor of the fixed two-chain NOR MIS test structure and sits at the top of the MIS test die, driven by the tester clock.

---
 rtl/nor_mis_sweep.sv | 155 +++++++++++++++
 tb/tb_nor_mis_sweep.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/nor_mis_sweep.sv
// nor_mis_sweep: self-stimulating NOR2 MIS skew sweep with edge counting per skew point.
// Glitch counting is built only when NOR_MIS_SWEEP_GLITCH_EN is defined.
module nor_mis_sweep #(
  parameter int CHAIN_DEPTH   = 11,
  parameter int OUT_DEPTH     = 6,
  parameter int MAX_SKEW      = 7,
  parameter int SETTLE_CYCLES = 8,
  parameter int REPEAT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [REPEAT_W-1:0] rep_cnt,
  output logic                busy,
  output logic                stim_a,
  output logic                stim_b,
  output logic                mis_out,
  output logic                result_valid,
  output logic [7:0]          result_skew,
  output logic [15:0]         edge_cnt,
  output logic [REPEAT_W-1:0] glitch_cnt
);
  typedef enum logic [2:0] {IDLE, LAUNCH1, SKEW_WAIT, LAUNCH2, SETTLE, RECORD, REPORT, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] skew_q, skew_d, mag, tedge_q, tedge_d;
  logic [REPEAT_W-1:0] trial_q, trial_d, reps_q, reps_d;
  logic [15:0] cnt_q, cnt_d, edge_q, edge_d;
  logic [16:0] sum;
  logic stim_a_q, stim_a_d, stim_b_q, stim_b_d, sync1_q, sync2_q, prev_q, l1_q, cnt_en;
  logic [CHAIN_DEPTH:0] ch_a, ch_b;
  logic [OUT_DEPTH:0] ch_o;
  assign ch_a[0] = stim_a_q;
  assign ch_b[0] = stim_b_q;
  genvar i;
  for (i = 0; i < CHAIN_DEPTH; i++) begin : g_in
    assign ch_a[i+1] = ~(ch_a[i] | 1'b0);
    assign ch_b[i+1] = ~(1'b0 | ch_b[i]);
  end
  assign ch_o[0] = ~(ch_a[CHAIN_DEPTH] | ch_b[CHAIN_DEPTH]);
  for (i = 0; i < OUT_DEPTH; i++) begin : g_out
    assign ch_o[i+1] = ~(1'b0 | ch_o[i]);
  end
  assign mis_out = ch_o[OUT_DEPTH];
  assign mag = skew_q[7] ? 8'(-skew_q) : skew_q;
  always_comb begin
    state_d = state_q;
    skew_d  = skew_q;
    trial_d = trial_q;
    reps_d  = reps_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LAUNCH1;
        skew_d  = 8'(-MAX_SKEW);
        trial_d = '0;
        reps_d  = (rep_cnt == '0) ? REPEAT_W'(1) : rep_cnt;
      end
      LAUNCH1: begin
        state_d = (mag > 8'd1) ? SKEW_WAIT : (mag != 8'd0) ? LAUNCH2 : SETTLE;
        cnt_d   = (mag > 8'd1) ? 16'(mag) - 16'd2 : 16'(SETTLE_CYCLES - 1);
      end
      SKEW_WAIT: begin
        state_d = (cnt_q == '0) ? LAUNCH2 : SKEW_WAIT;
        cnt_d   = cnt_q - 16'd1;
      end
      LAUNCH2: begin
        state_d = SETTLE;
        cnt_d   = 16'(SETTLE_CYCLES - 1);
      end
      SETTLE: begin
        state_d = (cnt_q == '0) ? RECORD : SETTLE;
        cnt_d   = cnt_q - 16'd1;
      end
      RECORD: begin
        state_d = (trial_q == reps_q - 1'b1) ? REPORT : LAUNCH1;
        trial_d = trial_q + 1'b1;
      end
      REPORT: begin
        state_d = (skew_q == 8'(MAX_SKEW)) ? DONE : LAUNCH1;
        skew_d  = (skew_q == 8'(MAX_SKEW)) ? skew_q : skew_q + 8'd1;
        trial_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Stimuli are set on entry to the launch states, so the toggle is visible in the launch cycle itself.
  always_comb begin
    stim_a_d = (state_d == REPORT) ? 1'b0 : stim_a_q;
    stim_b_d = (state_d == REPORT) ? 1'b0 : stim_b_q;
    if (state_d == LAUNCH1) begin
      stim_a_d = ~skew_d[7] ? ~trial_d[0] : stim_a_d;
      stim_b_d = (skew_d[7] || skew_d == '0) ? ~trial_d[0] : stim_b_d;
    end
    if (state_d == LAUNCH2) begin
      stim_a_d = skew_q[7] ? ~trial_q[0] : stim_a_d;
      stim_b_d = ~skew_q[7] ? ~trial_q[0] : stim_b_d;
    end
  end
  // The cycle after LAUNCH1 is masked: any edge flagged there was launched before this trial.
  assign cnt_en  = (state_q == SKEW_WAIT || state_q == LAUNCH2 || state_q == SETTLE) && !l1_q;
  assign tedge_d = (state_q == LAUNCH1) ? '0 :
                   (cnt_en && (sync2_q ^ prev_q) && ~&tedge_q) ? tedge_q + 8'd1 : tedge_q;
  assign sum     = {1'b0, edge_q} + 17'(tedge_q);
  assign edge_d  = (state_q == LAUNCH1 && trial_q == '0) ? '0 :
                   (state_q == RECORD) ? (sum[16] ? 16'hFFFF : sum[15:0]) : edge_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      skew_q   <= '0;
      trial_q  <= '0;
      reps_q   <= '0;
      cnt_q    <= '0;
      stim_a_q <= 1'b0;
      stim_b_q <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      l1_q     <= 1'b0;
      tedge_q  <= '0;
      edge_q   <= '0;
    end else begin
      state_q  <= state_d;
      skew_q   <= skew_d;
      trial_q  <= trial_d;
      reps_q   <= reps_d;
      cnt_q    <= cnt_d;
      stim_a_q <= stim_a_d;
      stim_b_q <= stim_b_d;
      sync1_q  <= mis_out;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      l1_q     <= (state_q == LAUNCH1);
      tedge_q  <= tedge_d;
      edge_q   <= edge_d;
    end
  end
`ifdef NOR_MIS_SWEEP_GLITCH_EN
  logic [REPEAT_W-1:0] glitch_q, glitch_d;
  assign glitch_d = (state_q == LAUNCH1 && trial_q == '0) ? '0 :
                    (state_q == RECORD && tedge_q > 8'd1 && ~&glitch_q) ? glitch_q + 1'b1 : glitch_q;
  always_ff @(posedge clk) begin
    if (!rst_n) glitch_q <= '0;
    else glitch_q <= glitch_d;
  end
  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = '0;
`endif
  assign busy         = (state_q != IDLE);
  assign stim_a       = stim_a_q;
  assign stim_b       = stim_b_q;
  assign result_valid = (state_q == REPORT);
  assign result_skew  = skew_q;
  assign edge_cnt     = edge_q;
endmodule

// File: tb/tb_nor_mis_sweep.sv
// tb_nor_mis_sweep: per-cycle schedule model of the skew sweep plus literal pins on lengths and alignment.
module tb_nor_mis_sweep;
  localparam int CD = 11, OD = 6, M = 3, S = 16, RW = 8;
`ifdef NOR_MIS_SWEEP_GLITCH_EN
  localparam int GEN = 1;
`else
  localparam int GEN = 0;
`endif
  logic clk = 0, rst_n = 0, start = 0;
  logic [RW-1:0] rep_cnt = '0;
  logic busy, stim_a, stim_b, mis_out, result_valid;
  logic [7:0] result_skew;
  logic [15:0] edge_cnt;
  logic [RW-1:0] glitch_cnt;
  typedef struct {logic busy, a, b, rv; logic [7:0] skew; logic [15:0] ecnt; logic [RW-1:0] gcnt;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, busy_cyc = 0, rv_n = 0, ta = 0, d_last = 0;
  int d_at[8];
  logic run = 0, inj = 0, pa = 0, pb = 0;
  always #5 clk = ~clk;
  nor_mis_sweep #(.CHAIN_DEPTH(CD), .OUT_DEPTH(OD), .MAX_SKEW(M), .SETTLE_CYCLES(S), .REPEAT_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rep_cnt(rep_cnt), .busy(busy), .stim_a(stim_a),
    .stim_b(stim_b), .mis_out(mis_out), .result_valid(result_valid), .result_skew(result_skew),
    .edge_cnt(edge_cnt), .glitch_cnt(glitch_cnt));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", n, cyc, act, exp);
    end
  endtask
  function automatic void push(input logic bz, input logic a, input logic b, input logic rv,
                               input int sk, input int ec, input int gc);
    exp_t e;
    e.busy = bz; e.a = a; e.b = b; e.rv = rv;
    e.skew = 8'(sk); e.ecnt = 16'(ec); e.gcnt = RW'(gc);
    exp_q.push_back(e);
  endfunction
  // Whole-sweep schedule: each trial is the lead phase, then both stimuli at the trial polarity.
  task automatic build(input int r, input int gp, input int extra);
    int reps, mag;
    logic v;
    reps = (r == 0) ? 1 : r;
    for (int s = -M; s <= M; s++) begin
      mag = (s < 0) ? -s : s;
      for (int k = 0; k < reps; k++) begin
        v = (k % 2 == 0);
        for (int c = 0; c < 1 + ((mag > 1) ? mag - 1 : 0); c++)
          push(1, (s >= 0) ? v : !v, (s <= 0) ? v : !v, 0, 0, 0, 0);
        for (int c = 0; c < S + 1 + ((s != 0) ? 1 : 0); c++) push(1, v, v, 0, 0, 0, 0);
      end
      push(1, 0, 0, 1, s, reps + ((s + M == gp) ? extra : 0), (s + M == gp && extra > 0) ? GEN : 0);
    end
    push(1, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    exp_t e;
    logic ca, cb, em;
    wait (run);
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e.busy = 0; e.a = 0; e.b = 0; e.rv = 0; e.skew = 0; e.ecnt = 0; e.gcnt = 0;
      end
      chk("busy", 32'(busy), 32'(e.busy));
      chk("stim_a", 32'(stim_a), 32'(e.a));
      chk("stim_b", 32'(stim_b), 32'(e.b));
      chk("result_valid", 32'(result_valid), 32'(e.rv));
      ca = (CD % 2 == 1) ? !e.a : e.a;
      cb = (CD % 2 == 1) ? !e.b : e.b;
      em = (OD % 2 == 1) ? (ca | cb) : !(ca | cb);
      if (!inj) chk("mis_out", 32'(mis_out), 32'(em));
      if (e.rv) begin
        chk("result_skew", 32'(result_skew), 32'(e.skew));
        chk("edge_cnt", 32'(edge_cnt), 32'(e.ecnt));
        chk("glitch_cnt", 32'(glitch_cnt), 32'(e.gcnt));
      end
      if (busy) busy_cyc++;
      if (stim_a && !pa) ta = cyc;
      if (stim_b && !pb) d_last = cyc - ta;
      if (result_valid && rv_n < 8) d_at[rv_n] = d_last;
      if (result_valid) rv_n++;
      pa = stim_a;
      pb = stim_b;
    end
  end
  task automatic sweep(input int r, input int gp, input int extra, input int len, input int mid);
    int n;
    @(negedge clk);
    rep_cnt = RW'(r);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    build(r, gp, extra);
    busy_cyc = 0;
    rv_n = 0;
    chk("model_len", 32'(exp_q.size()), 32'(len));
    if (extra > 0) begin
      for (n = 0; n < 100 && !stim_a; n++) @(negedge clk);
      chk("inj_arm", 32'(stim_a), 32'd1);
      @(negedge clk) inj = 1;
      // Both stimuli are high here, so the settled output is 1; each forced-low pulse adds two edges.
      @(negedge clk) force dut.mis_out = 1'b0;
      repeat (2) @(negedge clk);
      release dut.mis_out;
      repeat (2) @(negedge clk);
      force dut.mis_out = 1'b0;
      repeat (2) @(negedge clk);
      release dut.mis_out;
      @(negedge clk) inj = 0;
    end
    if (mid != 0) begin
      repeat (30) @(negedge clk);
      rep_cnt = RW'(9);
      start = 1;
      @(negedge clk) start = 0;
    end
    for (n = 0; n < 3000 && busy; n++) @(negedge clk);
    chk("sweep_end", 32'(busy), 32'd0);
    chk("busy_cycles", 32'(busy_cyc), 32'(len));
    chk("points", 32'(rv_n), 32'(2 * M + 1));
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog cycle %0d got timeout expected finish", cyc);
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stim", 32'({stim_a, stim_b}), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_skew", 32'(result_skew), 32'd0);
    chk("rst_edge", 32'(edge_cnt), 32'd0);
    chk("rst_glitch", 32'(glitch_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    run = 1;
    sweep(4, -1, 0, 560, 0);
    chk("align_s0", 32'(d_at[3]), 32'd0);
    chk("align_s3", 32'(d_at[6]), 32'd3);
    chk("final_edge_rep4", 32'(edge_cnt), 32'd4);
    chk("final_skew", 32'(result_skew), 32'd3);
    sweep(0, -1, 0, 146, 1);
    chk("final_edge_rep0", 32'(edge_cnt), 32'd1);
    sweep(1, 0, 4, 146, 0);
    @(negedge clk);
    rep_cnt = RW'(4);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    build(4, -1, 0);
    rv_n = 0;
    repeat (50) @(posedge clk);
    chk("pre_rst_edge", 32'(edge_cnt), 32'd2);
    #1 rst_n = 0;
    @(posedge clk);
    #1 exp_q.delete();
    rst_n = 1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_edge", 32'(edge_cnt), 32'd0);
    chk("mid_rst_skew", 32'(result_skew), 32'd0);
    chk("mid_rst_points", 32'(rv_n), 32'd0);
    repeat (3) @(negedge clk);
    sweep(2, -1, 0, 284, 0);
    chk("final_edge_rep2", 32'(edge_cnt), 32'd2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
